// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the register file and the hazard unit:
//   default widths, the hardwired-zero index and a helper that extracts one
//   port's field from a packed multi-port vector.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int ZERO_IDX     = 0;

    // Upper bounds used by rf_slice; callers zero-pad into this width.
    localparam int RF_MAX_PORTS = 4;
    localparam int RF_MAX_W     = 16;
    localparam int RF_VEC_W     = RF_MAX_PORTS * RF_MAX_W;

    // Returns field k (each w bits wide) of a packed vector, zero-extended to
    // RF_MAX_W. A shift is used instead of a part-select because w is not a
    // constant inside the function.
    function automatic logic [RF_MAX_W-1:0] rf_slice(
        input logic [RF_VEC_W-1:0] addr_vec,
        input int                  k,
        input int                  w
    );
        logic [RF_VEC_W-1:0] shifted;
        logic [RF_MAX_W-1:0] field;
        shifted = addr_vec >> (k * w);
        field   = shifted[RF_MAX_W-1:0];
        for (int b = 0; b < RF_MAX_W; b++) begin
            if (b >= w) begin
                field[b] = 1'b0;
            end
        end
        return field;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
//   One combinational read port: zero-register override, same-cycle write
//   bypass, otherwise the stored array word. Busy is the pending bit of the
//   addressed register, masked when the write port is retiring it this cycle.
// Ports
//   rd_addr   in   register index for this port
//   arr_data  in   stored word at rd_addr (array lookup done by the parent)
//   pend_bit  in   pending flag at rd_addr
//   wr_en     in   write port enable
//   wr_addr   in   write port index
//   wr_data   in   write port data
//   rd_data   out  read result
//   rd_busy   out  a write to rd_addr is still outstanding
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              pend_bit,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic bypass_hit;
    logic is_zero;

    always_comb begin
        bypass_hit = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
        is_zero    = (ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_IDX));

        if (is_zero) begin
            rd_data = '0;
        end else if (bypass_hit) begin
            rd_data = wr_data;
        end else begin
            rd_data = arr_data;
        end

        // The producer is delivering its value right now, so the consumer
        // can take the bypassed data without stalling.
        rd_busy = pend_bit && !bypass_hit && !is_zero;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Multi-read-port register file with a per-register pending-write
//   scoreboard for the ID stage. Reads are combinational with optional
//   write-data bypass; busy flags feed the hazard unit.
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   rd_addr     in   packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   rd_data     out  packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy     out  per-port outstanding-write flag
//   wr_en       in   commit a write this cycle
//   wr_addr     in   write index
//   wr_data     in   write data
//   issue_en    in   reserve issue_addr for an in-flight producer
//   issue_addr  in   destination index being reserved
//   flush       in   drop every reservation
//   pend_cnt    out  number of pending bits currently set
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    if (NUM_RD < 1 || NUM_RD > RF_MAX_PORTS) begin : g_bad_num_rd
        $error("regfile_scoreboard: NUM_RD=%0d outside 1..4", NUM_RD);
    end
    if (ADDR_W > RF_MAX_W) begin : g_bad_addr_w
        $error("regfile_scoreboard: ADDR_W=%0d too wide", ADDR_W);
    end

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;
    logic [ADDR_W:0]   pend_cnt_q;
    logic [ADDR_W:0]   pend_cnt_d;

    logic wr_ok;
    logic issue_ok;
    logic pend_inc;
    logic pend_dec;

    always_comb begin
        wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_IDX)));
        issue_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == ADDR_W'(ZERO_IDX)));

        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end

        // Clear-then-set ordering makes an issue win over a write to the
        // same index: the issuing instruction is the newer producer.
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else begin
            if (wr_en) begin
                pending_d[wr_addr] = 1'b0;
            end
            if (issue_ok) begin
                pending_d[issue_addr] = 1'b1;
            end
        end

        // Count moves by at most one each way per cycle. A set only counts
        // when the bit was clear; a clear only counts when the bit was set
        // and is not being re-reserved in the same cycle.
        pend_inc = issue_ok && !pending_q[issue_addr];
        pend_dec = wr_en && pending_q[wr_addr] &&
                   !(issue_ok && (issue_addr == wr_addr));

        pend_cnt_d = pend_cnt_q;
        if (flush) begin
            pend_cnt_d = '0;
        end else if (pend_inc && !pend_dec) begin
            pend_cnt_d = pend_cnt_q + (ADDR_W+1)'(1);
        end else if (pend_dec && !pend_inc && (pend_cnt_q != '0)) begin
            pend_cnt_d = pend_cnt_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    // Zero-pad the packed address bus so rf_slice can work on a fixed width.
    logic [RF_VEC_W-1:0] rd_addr_pad;

    always_comb begin
        rd_addr_pad = '0;
        rd_addr_pad[NUM_RD*ADDR_W-1:0] = rd_addr;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] port_addr;

        assign port_addr = ADDR_W'(rf_slice(rd_addr_pad, k, ADDR_W));

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .rd_addr  (port_addr),
            .arr_data (regs_q[port_addr]),
            .pend_bit (pending_q[port_addr]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Scoreboard bench: each stimulus cycle pushes the expected read/busy/count
//   values computed from an array model; a monitor pops and compares at the
//   falling edge, after inputs have settled.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic             clk;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             issue_en;
    logic [AW-1:0]    issue_addr;
    logic             flush;
    logic [AW:0]      pend_cnt;

    regfile_scoreboard #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .BYPASS   (1),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .pend_cnt   (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    busy;
        logic [AW:0]      cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: plain register contents and a set of reserved indices.
    logic [DW-1:0] m_regs [32];
    bit            m_pend [32];

    task automatic applyStimulus(
        input bit            rst,
        input logic [19:0]   ra,
        input bit            we,
        input logic [4:0]    wa,
        input logic [31:0]   wd,
        input bit            ie,
        input logic [4:0]    ia,
        input bit            fl,
        input string         tag,
        input bit            chk
    );
        exp_t        e;
        int          n;
        logic [4:0]  a;
        @(posedge clk);
        #1;
        reset      = rst;
        rd_addr    = ra;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = ia;
        flush      = fl;
        if (chk) begin
            n = 0;
            for (int i = 0; i < 32; i++) begin
                if (m_pend[i]) n++;
            end
            e.cnt = 6'(n);
            for (int k = 0; k < NR; k++) begin
                a = ra[k*AW +: AW];
                if (a == 0) begin
                    e.data[k*DW +: DW] = '0;
                end else if (we && wa == a) begin
                    e.data[k*DW +: DW] = wd;
                end else begin
                    e.data[k*DW +: DW] = m_regs[a];
                end
                e.busy[k] = (a != 0) && m_pend[a] && !(we && wa == a);
            end
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) m_regs[wa] = wd;
            if (fl) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            end else begin
                if (we) m_pend[wa] = 1'b0;
                if (ie && ia != 0) m_pend[ia] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        for (int k = 0; k < NR; k++) begin
            total++;
            if (rd_data[k*DW +: DW] !== e.data[k*DW +: DW]) begin
                bad++;
                $display("[TB] FAIL %s rd_data%0d got=%h want=%h",
                         tag, k, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
            end
        end
        total++;
        if (rd_busy !== e.busy) begin
            bad++;
            $display("[TB] FAIL %s rd_busy got=%b want=%b", tag, rd_busy, e.busy);
        end
        total++;
        if (pend_cnt !== e.cnt) begin
            bad++;
            $display("[TB] FAIL %s pend_cnt got=%0d want=%0d", tag, pend_cnt, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checkOutput(e, t);
        end
    end

    function automatic logic [4:0] rndAddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    // Port order in the packed bus: {port3, port2, port1, port0}.
    function automatic logic [19:0] ports(input logic [4:0] p0, input logic [4:0] p1,
                                          input logic [4:0] p2, input logic [4:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    initial begin
        reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;

        applyStimulus(1, ports(5, 31, 0, 17), 0, 0, 0, 0, 0, 0, "reset", 0);
        applyStimulus(0, ports(5, 31, 0, 17), 0, 0, 0, 0, 0, 0, "after_reset", 1);

        applyStimulus(0, ports(3, 0, 0, 0), 1, 3, 32'hDEADBEEF, 0, 0, 0, "bypass_wr3", 1);
        applyStimulus(0, ports(3, 0, 0, 0), 0, 0, 0, 0, 0, 0, "stored_rd3", 1);

        applyStimulus(0, ports(0, 0, 3, 0), 1, 0, 32'h1234, 0, 0, 0, "wr_zero", 1);
        applyStimulus(0, ports(0, 0, 0, 0), 0, 0, 0, 1, 0, 0, "issue_zero", 1);
        applyStimulus(0, ports(0, 0, 0, 0), 0, 0, 0, 0, 0, 0, "zero_after", 1);

        applyStimulus(0, ports(7, 0, 0, 0), 0, 0, 0, 1, 7, 0, "issue7", 1);
        applyStimulus(0, ports(7, 7, 0, 0), 0, 0, 0, 0, 0, 0, "busy7", 1);
        applyStimulus(0, ports(7, 0, 0, 0), 1, 7, 32'h55, 0, 0, 0, "wr7_bypass", 1);
        applyStimulus(0, ports(7, 0, 0, 0), 0, 0, 0, 0, 0, 0, "after_wr7", 1);

        applyStimulus(0, ports(9, 0, 0, 0), 0, 0, 0, 1, 9, 0, "issue9", 1);
        applyStimulus(0, ports(9, 0, 0, 0), 1, 9, 32'hAA, 1, 9, 0, "issue_wr9", 1);
        applyStimulus(0, ports(9, 0, 0, 0), 0, 0, 0, 0, 0, 0, "after9", 1);

        applyStimulus(0, ports(1, 2, 3, 9), 0, 0, 0, 1, 1, 0, "issue1", 1);
        applyStimulus(0, ports(1, 2, 3, 9), 0, 0, 0, 1, 2, 0, "issue2", 1);
        applyStimulus(0, ports(1, 2, 3, 9), 0, 0, 0, 1, 3, 0, "issue3", 1);
        applyStimulus(0, ports(1, 2, 3, 9), 1, 2, 32'h77, 0, 0, 1, "flush_wr2", 1);
        applyStimulus(0, ports(1, 2, 3, 9), 0, 0, 0, 1, 4, 0, "after_flush", 1);
        applyStimulus(1, ports(2, 3, 4, 7), 0, 0, 0, 1, 5, 0, "mid_reset", 1);
        applyStimulus(0, ports(2, 3, 4, 5), 0, 0, 0, 0, 0, 0, "post_reset", 1);

        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          ports(rndAddr(), rndAddr(), rndAddr(), rndAddr()),
                          $urandom_range(0, 1) == 1, rndAddr(), $urandom,
                          $urandom_range(0, 9) < 4, rndAddr(),
                          $urandom_range(0, 99) < 5, "random", 1);
        end

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain pending got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
